rw_walk_engine: RTL and testbench

- Parametrised, fully synchronous random-walk engine for personalised-PageRank scoring. It owns one single-port BRAM port.
- For each seed it runs M_RW walks of up to MAX_STEPS steps over a CSR-style graph held in BRAM.
- Each visited (seed, step, node) triple has a visit counter in BRAM, which the engine increments on every visit.
- It replaces divided-clock sequencing with one FSM, an LFSR random source and a grant handshake, so the port can be shared with the PS loader.

---
 rtl/rw_walk_engine.sv | 213 +++++++++++++++++++++
 tb/tb_rw_walk_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rw_walk_engine.sv
// Random-walk engine for personalised-PageRank visit counting over a CSR graph held in one BRAM port.
// Latency: 2 cycles per seed fetch, 10 cycles per step with the grant held, 3 cycles of start/finish overhead.
// Backpressure: i_mem_gnt low freezes the FSM, and address, data and strobe are held until the access is accepted.
//
// Ports: i_clk/i_rst (async active-high); i_start begins a run (seen in IDLE only);
//        o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata + i_mem_gnt/i_mem_rdata form the shared BRAM port;
//        o_busy/o_done report run status; o_dead_ends counts walks cut short; o_sat_flag is sticky counter saturation.
module rw_walk_engine #(
    parameter int          ADDR_W          = 13,
    parameter int          DATA_W          = 32,
    parameter int          SEED_NUM        = 10,
    parameter int          M_RW            = 100,
    parameter int          MAX_STEPS       = 7,
    parameter int          NODE_NUM        = 100,
    parameter int          NEI_ADDR_OFFSET = 10,
    parameter int          SCORE_OFFSET    = 1000,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_0001
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_mem_gnt,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_dead_ends,
    output logic              o_sat_flag
);
    localparam int S_W = $clog2(SEED_NUM + 1);
    localparam int W_W = $clog2(M_RW + 1);
    localparam int K_W = $clog2(MAX_STEPS + 1);

    typedef enum logic [3:0] {
        IDLE, SEED_RD, SEED_CAP, FA_RD, FA_CAP, LA_RD, LA_CAP,
        NB_RD, NB_CAP, CNT_RD, CNT_CAP, CNT_WR, ADV, FIN
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [S_W-1:0]      r_s;
    logic [W_W-1:0]      r_w;
    logic [K_W-1:0]      r_k;
    logic [ADDR_W-1:0]   r_start_node, r_curr, r_next, r_nb_addr, r_cnt_addr;
    logic [DATA_W-1:0]   r_first, r_wdata;
    logic [31:0]         r_lfsr;
    logic [15:0]         r_dead;
    logic                r_sat, r_busy, r_done;

    logic [DATA_W-1:0]   w_deg;
    logic                w_dead;
    logic [31:0]         w_prod;
    logic [ADDR_W-1:0]   w_nb_addr, w_cnt_addr;
    logic [31:0]         w_lfsr_nxt;
    logic                w_cnt_sat;
    logic [S_W-1:0]      w_s_inc;
    logic [W_W-1:0]      w_w_inc;
    logic [K_W-1:0]      w_k_inc;
    logic                w_more_steps, w_more_walks, w_more_seeds;
    logic                w_unused;

    // i_mem_rdata holds the last-neighbour address while in LA_CAP.
    assign w_dead     = i_mem_rdata < r_first;
    assign w_deg      = i_mem_rdata - r_first + DATA_W'(1);
    // Scaling a 16-bit uniform value by deg and keeping the top half gives 0 <= idx < deg without a divider.
    assign w_prod     = {16'b0, r_lfsr[15:0]} * {16'b0, w_deg[15:0]};
    assign w_nb_addr  = r_first[ADDR_W-1:0] + ADDR_W'(w_prod[31:16]);
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h8020_0003) : (r_lfsr >> 1);
    // i_mem_rdata holds the next node while in NB_CAP; everything wraps modulo 2^ADDR_W.
    assign w_cnt_addr = ADDR_W'(SCORE_OFFSET)
                      + (ADDR_W'(r_s) * ADDR_W'(MAX_STEPS) + ADDR_W'(r_k)) * ADDR_W'(NODE_NUM)
                      + i_mem_rdata[ADDR_W-1:0];
    assign w_cnt_sat  = &i_mem_rdata;

    assign w_s_inc      = r_s + S_W'(1);
    assign w_w_inc      = r_w + W_W'(1);
    assign w_k_inc      = r_k + K_W'(1);
    assign w_more_steps = r_k < K_W'(MAX_STEPS);
    assign w_more_walks = w_w_inc < W_W'(M_RW);
    assign w_more_seeds = w_s_inc < S_W'(SEED_NUM);
    assign w_unused     = ^{w_deg[DATA_W-1:16], w_prod[15:0]};

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_dead_ends = r_dead;
    assign o_sat_flag  = r_sat;

    always_comb begin
        w_state_nxt = r_state;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            IDLE:     if (i_start) w_state_nxt = SEED_RD;
            SEED_RD: begin
                o_mem_en   = 1'b1;
                o_mem_addr = ADDR_W'(r_s);
                if (i_mem_gnt) w_state_nxt = SEED_CAP;
            end
            SEED_CAP: w_state_nxt = FA_RD;
            FA_RD: begin
                o_mem_en   = 1'b1;
                o_mem_addr = ADDR_W'(NEI_ADDR_OFFSET) + r_curr + r_curr;
                if (i_mem_gnt) w_state_nxt = FA_CAP;
            end
            FA_CAP:   w_state_nxt = LA_RD;
            LA_RD: begin
                o_mem_en   = 1'b1;
                o_mem_addr = ADDR_W'(NEI_ADDR_OFFSET) + r_curr + r_curr + ADDR_W'(1);
                if (i_mem_gnt) w_state_nxt = LA_CAP;
            end
            LA_CAP:   w_state_nxt = w_dead ? ADV : NB_RD;
            NB_RD: begin
                o_mem_en   = 1'b1;
                o_mem_addr = r_nb_addr;
                if (i_mem_gnt) w_state_nxt = NB_CAP;
            end
            NB_CAP:   w_state_nxt = CNT_RD;
            CNT_RD: begin
                o_mem_en   = 1'b1;
                o_mem_addr = r_cnt_addr;
                if (i_mem_gnt) w_state_nxt = CNT_CAP;
            end
            CNT_CAP:  w_state_nxt = CNT_WR;
            CNT_WR: begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = r_cnt_addr;
                o_mem_wdata = r_wdata;
                if (i_mem_gnt) w_state_nxt = ADV;
            end
            ADV: begin
                if (w_more_steps || w_more_walks) w_state_nxt = FA_RD;
                else if (w_more_seeds)            w_state_nxt = SEED_RD;
                else                              w_state_nxt = FIN;
            end
            FIN:      w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_w          <= '0;
            r_k          <= '0;
            r_start_node <= '0;
            r_curr       <= '0;
            r_next       <= '0;
            r_nb_addr    <= '0;
            r_cnt_addr   <= '0;
            r_first      <= '0;
            r_wdata      <= '0;
            r_lfsr       <= LFSR_SEED;
            r_dead       <= '0;
            r_sat        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_s    <= '0;
                    r_busy <= 1'b1;
                end
                SEED_CAP: begin
                    r_start_node <= i_mem_rdata[ADDR_W-1:0];
                    r_curr       <= i_mem_rdata[ADDR_W-1:0];
                    r_w          <= '0;
                    r_k          <= '0;
                end
                FA_CAP: r_first <= i_mem_rdata;
                LA_CAP: begin
                    if (w_dead) begin
                        if (r_dead != 16'hFFFF) r_dead <= r_dead + 16'd1;
                        r_k <= K_W'(MAX_STEPS);
                    end else begin
                        r_nb_addr <= w_nb_addr;
                        r_lfsr    <= w_lfsr_nxt;
                    end
                end
                NB_CAP: begin
                    r_next     <= i_mem_rdata[ADDR_W-1:0];
                    r_cnt_addr <= w_cnt_addr;
                end
                CNT_CAP: begin
                    r_wdata <= w_cnt_sat ? i_mem_rdata : i_mem_rdata + DATA_W'(1);
                    if (w_cnt_sat) r_sat <= 1'b1;
                end
                CNT_WR: if (i_mem_gnt) begin
                    r_curr <= r_next;
                    r_k    <= w_k_inc;
                end
                ADV: if (!w_more_steps) begin
                    r_w    <= w_w_inc;
                    r_curr <= r_start_node;
                    r_k    <= '0;
                    if (!w_more_walks) r_s <= w_s_inc;
                end
                FIN: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rw_walk_engine.sv
// Directed bench for rw_walk_engine: two instances (one and three walks per seed) on a small hand-built graph.
// Each instance has its own behavioural BRAM with one-cycle read latency and a write log.
module tb_rw_walk_engine;
    localparam int LIMIT = 500;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        start1, gnt1, en1, we1, busy1, done1, sat1;
    logic [12:0] addr1;
    logic [31:0] wdata1, rdata1;
    logic [15:0] dead1;
    logic        start3, gnt3, en3, we3, busy3, done3, sat3;
    logic [12:0] addr3;
    logic [31:0] wdata3, rdata3;
    logic [15:0] dead3;

    logic [31:0] mem1 [0:8191];
    logic [31:0] mem3 [0:8191];
    logic [12:0] wlog1 [0:15];
    int nw1, nw3;
    int checks = 0;
    int errors = 0;

    rw_walk_engine #(.ADDR_W(13), .DATA_W(32), .SEED_NUM(1), .M_RW(1), .MAX_STEPS(2), .NODE_NUM(4),
                     .NEI_ADDR_OFFSET(16), .SCORE_OFFSET(64), .LFSR_SEED(32'hACE1_0001)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mem_gnt(gnt1), .o_mem_en(en1), .o_mem_we(we1),
        .o_mem_addr(addr1), .o_mem_wdata(wdata1), .i_mem_rdata(rdata1), .o_busy(busy1), .o_done(done1),
        .o_dead_ends(dead1), .o_sat_flag(sat1));

    rw_walk_engine #(.ADDR_W(13), .DATA_W(32), .SEED_NUM(1), .M_RW(3), .MAX_STEPS(2), .NODE_NUM(4),
                     .NEI_ADDR_OFFSET(16), .SCORE_OFFSET(64), .LFSR_SEED(32'hACE1_0001)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .i_mem_gnt(gnt3), .o_mem_en(en3), .o_mem_we(we3),
        .o_mem_addr(addr3), .o_mem_wdata(wdata3), .i_mem_rdata(rdata3), .o_busy(busy3), .o_done(done3),
        .o_dead_ends(dead3), .o_sat_flag(sat3));

    always @(posedge clk) begin
        if (en1 && gnt1) begin
            if (we1) begin
                mem1[addr1] = wdata1;
                if (nw1 < 16) wlog1[nw1] = addr1;
                nw1 = nw1 + 1;
            end else rdata1 <= mem1[addr1];
        end
        if (en3 && gnt3) begin
            if (we3) begin
                mem3[addr3] = wdata3;
                nw3 = nw3 + 1;
            end else rdata3 <= mem3[addr3];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero1(input string pfx);
        check({pfx, "_en"},    32'(en1), 32'd0);
        check({pfx, "_we"},    32'(we1), 32'd0);
        check({pfx, "_addr"},  32'(addr1), 32'd0);
        check({pfx, "_wdata"}, wdata1, 32'd0);
        check({pfx, "_busy"},  32'(busy1), 32'd0);
        check({pfx, "_done"},  32'(done1), 32'd0);
        check({pfx, "_dead"},  32'(dead1), 32'd0);
        check({pfx, "_sat"},   32'(sat1), 32'd0);
    endtask

    task automatic clear_scores1();
        for (int i = 64; i < 72; i++) mem1[i] = 32'd0;
        nw1 = 0;
    endtask

    // Runs dut1 from a start pulse until done (or until the write to 69 is visible when kill is set,
    // at which point reset is raised before that write can be accepted). cyc counts edges after start.
    task automatic run1(input bit rnd, input bit kill, output int cyc);
        bit          ps, fin;
        logic [12:0] pa;
        logic        pw;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 0; ps = 1'b0; fin = 1'b0; pa = '0; pw = 1'b0;
        while (!fin && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            if (ps) begin
                check("stall_addr", 32'(addr1), 32'(pa));
                check("stall_we", 32'(we1), 32'(pw));
            end
            if (kill && we1 && addr1 == 13'd69) begin
                rst = 1'b1;
                #1;
                fin = 1'b1;
            end else if (done1) begin
                fin = 1'b1;
            end else begin
                gnt1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                ps = en1 && !gnt1;
                pa = addr1;
                pw = we1;
            end
        end
        gnt1 = 1'b1;
        check("run_finished", 32'(fin), 32'd1);
    endtask

    initial begin
        int          cyc, busy_low, diff;
        logic [31:0] exp_img [0:7];
        exp_img = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; gnt1 = 1'b1; gnt3 = 1'b1;
        rdata1 = '0; rdata3 = '0; nw1 = 0; nw3 = 0;
        for (int i = 0; i < 8192; i++) begin
            mem1[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        for (int i = 0; i < 16; i++) wlog1[i] = '0;
        mem1[0] = 1; mem1[18] = 40; mem1[19] = 40; mem1[20] = 41; mem1[21] = 41; mem1[40] = 2; mem1[41] = 1;
        mem3[0] = 1; mem3[18] = 40; mem3[19] = 40; mem3[20] = 41; mem3[21] = 41; mem3[40] = 2; mem3[41] = 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero1("reset");
        check("reset_busy3", 32'(busy3), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic single walk: node 1 -> 2 -> 1, counters at 66 then 69.
        run1(1'b0, 1'b0, cyc);
        check("basic_latency", cyc, 32'd23);
        check("basic_nwrites", nw1, 32'd2);
        check("basic_wr0_addr", 32'(wlog1[0]), 32'd66);
        check("basic_wr1_addr", 32'(wlog1[1]), 32'd69);
        check("basic_m66", mem1[66], 32'd1);
        check("basic_m69", mem1[69], 32'd1);
        check("basic_busy_at_done", 32'(busy1), 32'd0);
        check("basic_dead", 32'(dead1), 32'd0);
        @(posedge clk); #1;
        check("basic_done_pulse", 32'(done1), 32'd0);

        // Three walks per seed on the second instance.
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 0; busy_low = 0;
        while (!done3 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            if (!done3 && !busy3) busy_low++;
        end
        check("m3_latency", cyc, 32'd63);
        check("m3_busy_gaps", busy_low, 32'd0);
        check("m3_m66", mem3[66], 32'd3);
        check("m3_m69", mem3[69], 32'd3);
        check("m3_nwrites", nw3, 32'd6);
        check("m3_dead", 32'(dead3), 32'd0);

        // Node 2 has an empty range: only step 0 is counted.
        clear_scores1();
        mem1[20] = 5; mem1[21] = 4;
        run1(1'b0, 1'b0, cyc);
        check("dead_latency", cyc, 32'd18);
        check("dead_nwrites", nw1, 32'd1);
        check("dead_m66", mem1[66], 32'd1);
        check("dead_m69", mem1[69], 32'd0);
        check("dead_count", 32'(dead1), 32'd1);
        mem1[20] = 41; mem1[21] = 41;
        rst = 1'b1; #1;
        check("dead_cleared", 32'(dead1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Saturated counter stays all-ones and raises the sticky flag.
        clear_scores1();
        mem1[66] = 32'hFFFF_FFFF;
        run1(1'b0, 1'b0, cyc);
        check("sat_m66", mem1[66], 32'hFFFF_FFFF);
        check("sat_m69", mem1[69], 32'd1);
        check("sat_flag", 32'(sat1), 32'd1);
        run1(1'b0, 1'b0, cyc);
        check("sat_m69_again", mem1[69], 32'd2);
        check("sat_sticky", 32'(sat1), 32'd1);
        rst = 1'b1; #1;
        check("sat_cleared", 32'(sat1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Random grant: same image as the always-granted run, strobes stable while stalled.
        clear_scores1();
        run1(1'b1, 1'b0, cyc);
        diff = 0;
        for (int i = 0; i < 8; i++) if (mem1[64 + i] !== exp_img[i]) diff++;
        check("gnt_image_diffs", diff, 32'd0);
        check("gnt_nwrites", nw1, 32'd2);

        // Reset while the step-1 counter write is pending, then rerun cleanly.
        clear_scores1();
        run1(1'b0, 1'b1, cyc);
        check_zero1("midrst");
        check("midrst_nwrites", nw1, 32'd1);
        check("midrst_m69", mem1[69], 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run1(1'b0, 1'b0, cyc);
        check("rerun_m66", mem1[66], 32'd2);
        check("rerun_m69", mem1[69], 32'd1);
        check("rerun_latency", cyc, 32'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
